// File: rtl/ex_mem_reg_if.sv
// Interface between the ID/EX register, the execute stage and the memory stage.
// The slave modport is the execute stage; the master modport is its environment.
interface ex_mem_reg_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic                  reg_write_enable_in;
  logic                  mem_write_enable_in;
  logic                  mem_to_reg_select_in;
  logic                  alu_src_select_in;
  logic [1:0]            alu_control_in;
  logic                  flag_write_in;
  logic [DATA_WIDTH-1:0] src_a_in;
  logic [DATA_WIDTH-1:0] src_b_in;
  logic [DATA_WIDTH-1:0] ext_imm_in;
  logic [DATA_WIDTH-1:0] store_data_in;
  logic [ADDR_WIDTH-1:0] write_addr_in;

  logic                  out_valid;
  logic                  out_ready;
  logic                  reg_write_enable_out;
  logic                  mem_write_enable_out;
  logic                  mem_to_reg_select_out;
  logic [DATA_WIDTH-1:0] alu_result_out;
  logic [DATA_WIDTH-1:0] store_data_out;
  logic [ADDR_WIDTH-1:0] write_addr_out;
  logic [3:0]            flags_out;

  modport slave (
    input  in_valid, flush, reg_write_enable_in, mem_write_enable_in,
           mem_to_reg_select_in, alu_src_select_in, alu_control_in,
           flag_write_in, src_a_in, src_b_in, ext_imm_in, store_data_in,
           write_addr_in, out_ready,
    output in_ready, out_valid, reg_write_enable_out, mem_write_enable_out,
           mem_to_reg_select_out, alu_result_out, store_data_out,
           write_addr_out, flags_out
  );

  modport master (
    output in_valid, flush, reg_write_enable_in, mem_write_enable_in,
           mem_to_reg_select_in, alu_src_select_in, alu_control_in,
           flag_write_in, src_a_in, src_b_in, ext_imm_in, store_data_in,
           write_addr_in, out_ready,
    input  in_ready, out_valid, reg_write_enable_out, mem_write_enable_out,
           mem_to_reg_select_out, alu_result_out, store_data_out,
           write_addr_out, flags_out
  );
endinterface

// File: rtl/ex_mem_reg.sv
// Execute stage: ALU on the ID/EX entry, EX/MEM register with a 2-entry skid
// buffer and the architectural NZCV register updated on retire.
//
// state    | meaning
// ST_EMPTY | no entry held, out_valid=0
// ST_ONE   | main register valid
// ST_TWO   | main and skid valid, in_ready=0
module ex_mem_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input logic          clk,
  input logic          reset,
  ex_mem_reg_if.slave  bus
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  typedef struct packed {
    logic                  reg_we;
    logic                  mem_we;
    logic                  m2r;
    logic                  fw;
    logic [3:0]            flags;
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] store;
    logic [ADDR_WIDTH-1:0] waddr;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q, new_e;
  logic [3:0] flags_q;
  logic in_ready_q;
  logic out_valid;
  logic accept, retire;

  logic [DATA_WIDTH-1:0] b_op, b_eff, res;
  logic [DATA_WIDTH:0]   sum;
  logic                  is_sub, c_f, v_f;

  always_comb begin
    b_op   = bus.alu_src_select_in ? bus.ext_imm_in : bus.src_b_in;
    is_sub = (bus.alu_control_in == 2'b01);
    b_eff  = is_sub ? ~b_op : b_op;
    // Single adder serves ADD and SUB; carry-in of 1 completes a + ~b + 1.
    sum    = {1'b0, bus.src_a_in} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, is_sub};
    c_f    = flags_q[1];
    v_f    = flags_q[0];
    res    = sum[DATA_WIDTH-1:0];
    case (bus.alu_control_in)
      2'b00, 2'b01: begin
        c_f = sum[DATA_WIDTH];
        v_f = (bus.src_a_in[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
              (res[DATA_WIDTH-1] != bus.src_a_in[DATA_WIDTH-1]);
      end
      2'b10:   res = bus.src_a_in & b_op;
      default: res = bus.src_a_in | b_op;
    endcase

    new_e.reg_we = bus.reg_write_enable_in;
    new_e.mem_we = bus.mem_write_enable_in;
    new_e.m2r    = bus.mem_to_reg_select_in;
    new_e.fw     = bus.flag_write_in;
    new_e.flags  = {res[DATA_WIDTH-1], (res == '0), c_f, v_f};
    new_e.result = res;
    new_e.store  = bus.store_data_in;
    new_e.waddr  = bus.write_addr_in;
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = bus.in_valid && in_ready_q && !bus.flush;
  assign retire    = out_valid && bus.out_ready && !bus.flush;

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !retire)      state_d = ST_TWO;
          else if (!accept && retire) state_d = ST_EMPTY;
        end
        ST_TWO:  if (retire) state_d = ST_ONE;
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      flags_q    <= 4'b0000;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
      if (retire && main_q.fw) flags_q <= main_q.flags;
      case (state_q)
        ST_EMPTY: if (accept) main_q <= new_e;
        ST_ONE: begin
          if (accept && retire) main_q <= new_e;
          else if (accept)      skid_q <= new_e;
        end
        ST_TWO:  if (retire) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign bus.in_ready              = in_ready_q;
  assign bus.out_valid             = out_valid;
  assign bus.reg_write_enable_out  = main_q.reg_we && out_valid;
  assign bus.mem_write_enable_out  = main_q.mem_we && out_valid;
  assign bus.mem_to_reg_select_out = main_q.m2r;
  assign bus.alu_result_out        = main_q.result;
  assign bus.store_data_out        = main_q.store;
  assign bus.write_addr_out        = main_q.waddr;
  assign bus.flags_out             = flags_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: stream, flags, immediates, back-pressure,
// flush and asynchronous reset, with hand-computed expected values.
module tb_ex_mem_reg;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ex_mem_reg_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  ex_mem_reg #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic sel, input logic fw,
                       input logic rwe, input logic mwe);
    bus.in_valid             = 1'b1;
    bus.alu_control_in       = op;
    bus.src_a_in             = a;
    bus.src_b_in             = b;
    bus.ext_imm_in           = imm;
    bus.alu_src_select_in    = sel;
    bus.flag_write_in        = fw;
    bus.reg_write_enable_in  = rwe;
    bus.mem_write_enable_in  = mwe;
    bus.mem_to_reg_select_in = 1'b0;
    bus.store_data_in        = ~a;
    bus.write_addr_in        = a[3:0];
  endtask

  task automatic send_retire(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] imm, input logic sel,
                             input logic [31:0] exp_res, input logic [3:0] exp_flags);
    drive(op, a, b, imm, sel, 1'b1, 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk({tag, "_res"}, bus.alu_result_out, exp_res);
    chk({tag, "_vld"}, {31'b0, bus.out_valid}, 32'd1);
    step();
    chk({tag, "_flags"}, {28'b0, bus.flags_out}, {28'b0, exp_flags});
    chk({tag, "_drain"}, {31'b0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;

    // Reset held for three cycles.
    repeat (3) step();
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_result", bus.alu_result_out, 32'd0);
    chk("rst_flags", {28'b0, bus.flags_out}, 32'd0);
    chk("rst_rwe", {31'b0, bus.reg_write_enable_out}, 32'd0);
    reset = 1'b1;
    step();
    chk("post_rst_ready", {31'b0, bus.in_ready}, 32'd1);

    // ADD 5+7 streamed straight through.
    drive(2'b00, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("add_res", bus.alu_result_out, 32'd12);
    chk("add_vld", {31'b0, bus.out_valid}, 32'd1);
    chk("add_waddr", {28'b0, bus.write_addr_out}, 32'd5);
    chk("add_rwe", {31'b0, bus.reg_write_enable_out}, 32'd1);
    step();
    chk("add_bubble_rwe", {31'b0, bus.reg_write_enable_out}, 32'd0);
    chk("add_hold_res", bus.alu_result_out, 32'd12);
    chk("add_noflags", {28'b0, bus.flags_out}, 32'd0);

    // Flag generation.
    send_retire("sub_eq", 2'b01, 32'd3, 32'd3, 32'd0, 1'b0, 32'd0, 4'b0110);
    send_retire("sub_neg", 2'b01, 32'd0, 32'd1, 32'd0, 1'b0, 32'hFFFF_FFFF, 4'b1000);
    send_retire("add_ovf", 2'b00, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 32'h8000_0000, 4'b1001);

    // Immediate operand with logic ops: C and V carried from 1001.
    send_retire("and_imm", 2'b10, 32'h0F0, 32'hDEAD, 32'hFF, 1'b1, 32'hF0, 4'b0001);
    send_retire("orr_imm", 2'b11, 32'h100, 32'hDEAD, 32'hFF, 1'b1, 32'h1FF, 4'b0001);

    // Back-pressure: A and B fill the stage, C is held by the source.
    bus.out_ready = 1'b0;
    drive(2'b00, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("bp_a_ready", {31'b0, bus.in_ready}, 32'd1);
    drive(2'b00, 32'd2, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("bp_b_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("bp_stall_res", bus.alu_result_out, 32'd2);
    drive(2'b00, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("bp_hold_res", bus.alu_result_out, 32'd2);
    chk("bp_hold_store", bus.store_data_out, ~32'd1);
    bus.out_ready = 1'b1;
    step();
    chk("bp_ret_b", bus.alu_result_out, 32'd4);
    chk("bp_ret_b_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_ret_c", bus.alu_result_out, 32'd6);
    chk("bp_ret_c_vld", {31'b0, bus.out_valid}, 32'd1);
    step();
    chk("bp_empty", {31'b0, bus.out_valid}, 32'd0);
    chk("bp_flags", {28'b0, bus.flags_out}, 32'd1);

    // Flush from TWO with flag-writing entries pending.
    bus.out_ready = 1'b0;
    drive(2'b01, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    drive(2'b01, 32'd0, 32'd1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    chk("fl_two_ready", {31'b0, bus.in_ready}, 32'd0);
    drive(2'b00, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_vld", {31'b0, bus.out_valid}, 32'd0);
    chk("fl_rwe", {31'b0, bus.reg_write_enable_out}, 32'd0);
    chk("fl_mwe", {31'b0, bus.mem_write_enable_out}, 32'd0);
    chk("fl_flags", {28'b0, bus.flags_out}, 32'd1);
    chk("fl_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    chk("fl_discard", {31'b0, bus.out_valid}, 32'd0);
    chk("fl_flags2", {28'b0, bus.flags_out}, 32'd1);
    // Flush while ready: the offered entry must still be dropped.
    drive(2'b00, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_rdy_discard", {31'b0, bus.out_valid}, 32'd0);

    // Asynchronous reset while stalled in TWO.
    bus.out_ready = 1'b0;
    drive(2'b00, 32'd4, 32'd4, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    drive(2'b00, 32'd6, 32'd6, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk("ar_pre_vld", {31'b0, bus.out_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_vld", {31'b0, bus.out_valid}, 32'd0);
    chk("ar_res", bus.alu_result_out, 32'd0);
    chk("ar_flags", {28'b0, bus.flags_out}, 32'd0);
    chk("ar_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("ar_rwe", {31'b0, bus.reg_write_enable_out}, 32'd0);
    #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("ar_rel_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    chk("ar_rel_empty", {31'b0, bus.out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Consumer end of the ID/EX interface: takes decoded control signals and operands from the ID/EX register and performs the execute-stage ALU operation.
- Registers the result into an EX/MEM pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
- Holds the architectural NZCV flag register, which updates only when an instruction retires out of this stage.
- Feeds the memory stage; back-pressure from memory propagates to ID/EX through in_ready.

Parameters:
DATA_WIDTH, 32, operand, immediate and result width
ADDR_WIDTH, 4, register-file write address width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  ID/EX entry valid
in_ready  output  1  stage can accept an entry this cycle
flush  input  1  synchronous pipeline flush
reg_write_enable_in  input  1  register write enable
mem_write_enable_in  input  1  memory write enable
mem_to_reg_select_in  input  1  memory-to-register select
alu_src_select_in  input  1  ALU operand B source: 1 = ext_imm_in, 0 = src_b_in
alu_control_in  input  2  00 ADD, 01 SUB, 10 AND, 11 ORR
flag_write_in  input  1  instruction sets flags
src_a_in  input  DATA_WIDTH  operand A
src_b_in  input  DATA_WIDTH  register operand B
ext_imm_in  input  DATA_WIDTH  extended immediate
store_data_in  input  DATA_WIDTH  store data
write_addr_in  input  ADDR_WIDTH  destination register
out_valid  output  1  EX/MEM entry valid
out_ready  input  1  memory stage accepts the entry
reg_write_enable_out  output  1  gated register write enable
mem_write_enable_out  output  1  gated memory write enable
mem_to_reg_select_out  output  1  memory-to-register select
alu_result_out  output  DATA_WIDTH  ALU result
store_data_out  output  DATA_WIDTH  store data
write_addr_out  output  ADDR_WIDTH  destination register
flags_out  output  4  architectural {N,Z,C,V}

Behaviour:
- Reset: asynchronous, asserts when reset=0. All entries are invalidated and all outputs go to 0; flags_out=4'b0000 and in_ready=0. in_ready becomes 1 on the first clk edge after reset deasserts. Reset mid-transfer drops both entries.
- Operand B: alu_src_select_in ? ext_imm_in : src_b_in.
- ALU is combinational on the inputs; the result is captured on accept.
  - ADD: a+b.
  - SUB: a-b (two's complement, a + ~b + 1).
  - AND: a&b.
  - ORR: a|b.
  - All results are truncated to DATA_WIDTH.
- Flag computation, captured per entry:
  - N = result[MSB].
  - Z = (result==0).
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = 1 when there is no borrow (a >= b unsigned); V = signed overflow.
  - AND/ORR: C and V keep the current flags_out values.
- Accept when in_valid && in_ready. Retire when out_valid && out_ready.
- Latency: an entry accepted at edge k is visible on the outputs after edge k. Throughput is 1 entry per cycle while out_ready=1.
- Storage: states EMPTY, ONE (main register valid), TWO (main + skid valid).
  - EMPTY: accept -> ONE.
  - ONE:
    - accept with retire -> ONE; the new entry goes to main.
    - accept without retire -> TWO; the new entry goes to skid.
    - retire without accept -> EMPTY.
  - TWO:
    - retire -> ONE; skid moves to main.
    - No accept is possible in TWO.
- in_ready: registered, equals (state != TWO). in_valid arriving while in_ready=0 is ignored; the source must hold it.
- Output stability: outputs change only on retire, flush or reset. They stay stable while out_valid=1 && out_ready=0.
- Bubble gating: when out_valid=0, reg_write_enable_out=0 and mem_write_enable_out=0. The data outputs hold their last values.
- Flags: flags_out updates at the retire edge with the retiring entry's flags, only if its flag_write is set. Entries that are flushed never update flags.
- Flush (priority over accept and retire):
  - Next state is EMPTY and out_valid=0 on the next cycle.
  - An input offered in the same cycle is discarded.
  - No retire and no flag update occur in the flush cycle.
  - in_ready=1 on the next cycle.
- Simultaneous accept + retire in ONE: both happen in the same edge, with no bubble.

Test Plan:
- Reset and stream: hold reset=0 for 3 cycles -> all outputs 0 and in_ready=0. Release reset, then send ADD a=5, b=7 with out_ready=1 -> alu_result_out=12 one cycle later, out_valid=1.
- Flags: SUB a=3, b=3 with flag_write -> at retire flags_out=0110 (Z=1, C=1). Then SUB a=0, b=1 -> flags_out=1000. Then ADD 0x7FFFFFFF+1 -> flags_out=1001.
- Immediate select and logic ops: alu_src_select=1, imm=0xFF, AND with a=0x0F0 -> result 0xF0. ORR with a=0x100 -> result 0x1FF. C and V are unchanged.
- Back-pressure: out_ready=0, offer 3 entries A, B, C -> A and B accepted, in_ready=0 after B, C held by the source. out_ready=1 -> A, B, C retire in order on consecutive cycles, with no loss or duplication.
- Flush: in state TWO with flag_write entries, assert flush together with in_valid -> next cycle out_valid=0, both write enables 0, flags_out unchanged, in_ready=1, and the offered entry is discarded.
- Async reset mid-stall: reset=0 between clock edges while in TWO -> outputs clear immediately with no clk edge; after release the stage is EMPTY.
